// File: rtl/led_serial_rx.sv
// Serial-to-parallel receiver for the LED shift-register link.
// It samples the link lines, rebuilds MSB-first frames and flags completed or aborted frames.
module led_serial_rx #(
    parameter int WIDTH        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             led_clk_in,
    input  logic             led_do_in,
    input  logic             led_clr_in,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] do_sync_q;
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic                   clk_del_q;

    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q;

    logic             sync_clk;
    logic             sync_do;
    logic             sync_clr_n;
    logic             shift_edge;
    logic [WIDTH-1:0] shifted;

    assign sync_clk   = clk_sync_q[SYNC_STAGES-1];
    assign sync_do    = do_sync_q[SYNC_STAGES-1];
    assign sync_clr_n = clr_sync_q[SYNC_STAGES-1];
    assign shift_edge = sync_clk & ~clk_del_q;
    assign shifted    = {shreg_q[WIDTH-2:0], sync_do};

    // Equal-depth chains keep data and shift clock cycle-aligned after synchronization.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            clk_sync_q <= '0;
            do_sync_q  <= '0;
            clr_sync_q <= '0;
            clk_del_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], led_clk_in};
            do_sync_q  <= {do_sync_q[SYNC_STAGES-2:0], led_do_in};
            clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], led_clr_in};
            clk_del_q  <= sync_clk;
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= (bit_cnt_d != '0);
        end
    end

    // Priority: clear over shift edge over idle timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (!sync_clr_n) begin
            shreg_d     = '0;
            bit_cnt_d   = '0;
            idle_cnt_d  = '0;
            frame_err_d = (bit_cnt_q != '0);
        end else if (shift_edge) begin
            idle_cnt_d = '0;
            shreg_d    = shifted;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d    = '0;
                data_d       = shifted;
                data_valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q == '0) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_MAX) begin
            frame_err_d = 1'b1;
            shreg_d     = '0;
            bit_cnt_d   = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_led_serial_rx.sv
// Self-checking bench for led_serial_rx: directed link scenarios plus randomized frames
// checked against a bit-accumulating reference model.
module tb_led_serial_rx;

    localparam int WIDTH        = 16;
    localparam int SYNC_STAGES  = 2;
    localparam int IDLE_TIMEOUT = 1024;

    logic             clk        = 1'b0;
    logic             RSTN       = 1'b0;
    logic             led_clk_in = 1'b0;
    logic             led_do_in  = 1'b0;
    logic             led_clr_in = 1'b1;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             frame_err;
    logic             busy;

    led_serial_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .led_clk_in(led_clk_in),
        .led_do_in (led_do_in),
        .led_clr_in(led_clr_in),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed events, sampled on the falling edge.
    logic [WIDTH-1:0] got_q[$];
    int unsigned      valid_cyc_q[$];
    int               err_cnt   = 0;
    int unsigned      err_cyc   = 0;
    bit               both_seen = 1'b0;
    int               busy_bad  = 0;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            got_q.push_back(data);
            valid_cyc_q.push_back(cyc);
        end
        if (frame_err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (data_valid === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
    end

    // Reference model: accumulate link bits; every WIDTH bits make one word.
    int               model_bits = 0;
    logic [WIDTH-1:0] model_word = '0;
    logic [WIDTH-1:0] exp_q[$];
    int               exp_err = 0;

    task automatic model_bit(input bit b);
        model_word = {model_word[WIDTH-2:0], b};
        model_bits = model_bits + 1;
        if (model_bits == WIDTH) begin
            exp_q.push_back(model_word);
            model_bits = 0;
            model_word = '0;
        end
    endtask

    task automatic model_abort();
        if (model_bits != 0) exp_err = exp_err + 1;
        model_bits = 0;
        model_word = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        valid_cyc_q.delete();
        exp_q.delete();
        err_cnt   = 0;
        exp_err   = 0;
        both_seen = 1'b0;
        busy_bad  = 0;
    endtask

    // One link bit: data set up a cycle early, clock high for hi cycles and low for lo cycles.
    task automatic send_bit(input bit b, input int hi, input int lo, output int unsigned rise);
        led_do_in = b;
        tick(1);
        led_clk_in = 1'b1;
        rise = cyc + 1;
        tick(hi);
        led_clk_in = 1'b0;
        tick(lo);
        model_bit(b);
        if ((model_bits != 0) && (busy !== 1'b1)) busy_bad = busy_bad + 1;
        if ((model_bits == 0) && (busy !== 1'b0)) busy_bad = busy_bad + 1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int nbits, input int hi, input int lo,
                             output int unsigned last_rise);
        for (int i = 0; i < nbits; i++) send_bit(w[WIDTH-1-i], hi, lo, last_rise);
    endtask

    task automatic pulse_clear(input int n);
        led_clr_in = 1'b0;
        tick(n);
        led_clr_in = 1'b1;
        model_abort();
        tick(SYNC_STAGES + 2);
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++;
        if (data !== '0 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h dv=%b fe=%b busy=%b, expected all 0",
                     data, data_valid, frame_err, busy);
        end
        RSTN = 1'b1;
        tick(SYNC_STAGES + 3);
        n_checks++;
        if (data !== '0 || busy !== 1'b0 || got_q.size() != 0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_release: data=%h busy=%b valids=%0d errs=%0d, expected 0/0/0/0",
                     data, busy, got_q.size(), err_cnt);
        end
    endtask

    task automatic test_full_frame();
        int unsigned r;
        clear_obs();
        send_word(16'hA5C3, WIDTH, 4, 4, r);
        tick(4);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL full_frame_data: %0d pulses, first=%h, expected 1 pulse of a5c3",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        n_checks++;
        if (valid_cyc_q.size() != 1 || valid_cyc_q[0] != r + SYNC_STAGES) begin
            n_fail++;
            $display("FAIL full_frame_latency: valid at cycle %0d, expected %0d",
                     (valid_cyc_q.size() > 0) ? valid_cyc_q[0] : 0, r + SYNC_STAGES);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL full_frame_busy: %0d wrong busy samples, expected 0", busy_bad);
        end
        n_checks++;
        if (err_cnt != 0 || both_seen || data !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL full_frame_hold: errs=%0d both=%b data=%h, expected 0/0/a5c3",
                     err_cnt, both_seen, data);
        end
    endtask

    task automatic test_adder_readback();
        int unsigned r;
        clear_obs();
        send_word({11'b0, 5'b10011}, WIDTH, 3, 2, r);
        tick(4);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'h0013 || data !== 16'h0013) begin
            n_fail++;
            $display("FAIL adder_readback: %0d pulses, data=%h, expected 1 pulse of 0013",
                     got_q.size(), data);
        end
    endtask

    task automatic test_timeout();
        int unsigned      r;
        int unsigned      due;
        logic [WIDTH-1:0] prev;
        prev = data;
        clear_obs();
        send_word(WIDTH'($urandom), 7, 4, 4, r);
        tick(IDLE_TIMEOUT + 50);
        model_abort();
        due = r + SYNC_STAGES + IDLE_TIMEOUT;
        n_checks++;
        if (err_cnt != exp_err || err_cyc + 1 < due || err_cyc > due + 1) begin
            n_fail++;
            $display("FAIL timeout_err: %0d pulses at cycle %0d, expected %0d pulse near %0d",
                     err_cnt, err_cyc, exp_err, due);
        end
        n_checks++;
        if (busy !== 1'b0 || data !== prev || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_state: busy=%b data=%h valids=%0d, expected 0/%h/0",
                     busy, data, got_q.size(), prev);
        end
        clear_obs();
        send_word(16'h1234, WIDTH, 2, 3, r);
        tick(4);
        n_checks++;
        if (got_q.size() != 1 || data !== 16'h1234 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL timeout_next_frame: %0d pulses data=%h errs=%0d, expected 1/1234/0",
                     got_q.size(), data, err_cnt);
        end
    endtask

    task automatic test_clear();
        int unsigned      r;
        logic [WIDTH-1:0] prev;
        prev = data;
        clear_obs();
        send_word(WIDTH'($urandom), 9, 4, 4, r);
        pulse_clear(3);
        n_checks++;
        if (err_cnt != 1 || data !== prev || got_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid_frame: errs=%0d data=%h valids=%0d busy=%b, expected 1/%h/0/0",
                     err_cnt, data, got_q.size(), busy, prev);
        end
        clear_obs();
        send_word(16'hBEEF, WIDTH, 4, 4, r);
        pulse_clear(3);
        n_checks++;
        if (got_q.size() != 1 || data !== 16'hBEEF || err_cnt != 0) begin
            n_fail++;
            $display("FAIL clear_after_frame: %0d pulses data=%h errs=%0d, expected 1/beef/0",
                     got_q.size(), data, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned r;
        clear_obs();
        send_word(16'hFFFF, WIDTH, 4, 4, r);
        send_word(16'h0000, WIDTH, 4, 4, r);
        tick(4);
        n_checks++;
        if (got_q.size() != 2 || got_q[0] !== 16'hFFFF || got_q[1] !== 16'h0000 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL back_to_back: %0d pulses first=%h errs=%0d, expected ffff,0000 and 0 errs",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int unsigned      r;
        logic [WIDTH-1:0] w;
        w = WIDTH'($urandom) | 16'h8001;
        send_word(w, WIDTH, 2, 2, r);
        tick(3);
        send_word(WIDTH'($urandom), 5, 3, 3, r);
        #2 RSTN = 1'b0;
        #1;
        n_checks++;
        if (data !== '0 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: data=%h dv=%b fe=%b busy=%b, expected all 0 (was %h)",
                     data, data_valid, frame_err, busy, w);
        end
        #9 RSTN = 1'b1;
        model_bits = 0;
        model_word = '0;
        tick(SYNC_STAGES + 3);
        clear_obs();
        send_word(16'h00FF, WIDTH, 4, 4, r);
        tick(4);
        n_checks++;
        if (got_q.size() != 1 || data !== 16'h00FF || err_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_next_frame: %0d pulses data=%h errs=%0d, expected 1/00ff/0",
                     got_q.size(), data, err_cnt);
        end
    endtask

    task automatic test_random();
        int unsigned r;
        int          bad;
        clear_obs();
        for (int i = 0; i < 24; i++) begin
            int hi;
            int lo;
            hi = $urandom_range(2, 5);
            lo = $urandom_range(2, 5);
            if ($urandom_range(0, 3) == 0) begin
                send_word(WIDTH'($urandom), $urandom_range(1, WIDTH - 1), hi, lo, r);
                pulse_clear($urandom_range(2, 4));
            end else begin
                send_word(WIDTH'($urandom), WIDTH, hi, lo, r);
            end
            tick($urandom_range(0, 3));
        end
        tick(4);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: %0d frames, expected %0d", got_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL random_data: %0d words differ from model", bad);
        end
        n_checks++;
        if (err_cnt != exp_err || both_seen || busy_bad != 0) begin
            n_fail++;
            $display("FAIL random_errors: errs=%0d both=%b busy_bad=%0d, expected %0d/0/0",
                     err_cnt, both_seen, busy_bad, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_adder_readback();
        test_timeout();
        test_clear();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
